// File: rtl/breakout_pkg.sv
// Shared breakout definitions: screen geometry, ball/paddle sizes,
// the ball-motion state enum and the direction types.
package breakout_pkg;

    localparam int SCREEN_W  = 640;
    localparam int SCREEN_H  = 480;
    localparam int BALL_SIZE = 8;
    localparam int PADDLE_W  = 64;

    // Park position after reset: centred horizontally, resting on a paddle at y=296.
    localparam int BALL_RESET_X = SCREEN_W / 2 - BALL_SIZE / 2;
    localparam int BALL_RESET_Y = 288;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        LOST = 2'd2
    } ball_state_t;

    typedef enum logic {
        DIR_RIGHT = 1'b0,
        DIR_LEFT  = 1'b1
    } x_dir_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } y_dir_t;

endpackage

// File: rtl/ball_motion.sv
// Per-frame ball motion engine: parks the ball on the paddle, moves it one
// step per frame, reflects off walls/paddle and pulses hit/miss.
module ball_motion #(
    parameter int SCREEN_W  = breakout_pkg::SCREEN_W,
    parameter int SCREEN_H  = breakout_pkg::SCREEN_H,
    parameter int BALL_SIZE = breakout_pkg::BALL_SIZE,
    parameter int PADDLE_W  = breakout_pkg::PADDLE_W,
    parameter int STEP      = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       launch,
    input  logic       pause,
    input  logic [9:0] paddle_x,
    input  logic [9:0] paddle_y,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic       hit,
    output logic       miss,
    output logic       active
);

    import breakout_pkg::*;

    // Compare constants are 11 bits wide so sums never wrap.
    localparam logic [10:0] STEP_W   = 11'(STEP);
    localparam logic [10:0] BALL_W   = 11'(BALL_SIZE);
    localparam logic [10:0] PAD_W    = 11'(PADDLE_W);
    localparam logic [10:0] X_MAX    = 11'(SCREEN_W - BALL_SIZE);
    localparam logic [10:0] Y_MAX    = 11'(SCREEN_H - BALL_SIZE);
    localparam logic [9:0]  STEP_10  = 10'(STEP);
    localparam logic [9:0]  BALL_10  = 10'(BALL_SIZE);
    localparam logic [9:0]  SNAP_OFS = 10'(PADDLE_W / 2 - BALL_SIZE / 2);
    localparam logic [9:0]  RESET_X  = 10'(BALL_RESET_X);
    localparam logic [9:0]  RESET_Y  = 10'(BALL_RESET_Y);

    ball_state_t state, state_next;
    x_dir_t      dx, dx_next, step_dx;
    y_dir_t      dy, dy_next, step_dy;
    logic [9:0]  x_next, y_next, step_x, step_y;
    logic        hit_next, miss_next, step_hit, step_miss;
    logic        over_paddle;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            ball_x <= RESET_X;
            ball_y <= RESET_Y;
            dx     <= DIR_RIGHT;
            dy     <= DIR_UP;
            hit    <= 1'b0;
            miss   <= 1'b0;
        end else begin
            state  <= state_next;
            ball_x <= x_next;
            ball_y <= y_next;
            dx     <= dx_next;
            dy     <= dy_next;
            hit    <= hit_next;
            miss   <= miss_next;
        end
    end

    assign active = (state == MOVE);

    assign over_paddle = (({1'b0, ball_x} + BALL_W) > {1'b0, paddle_x}) &&
                         ({1'b0, ball_x} < ({1'b0, paddle_x} + PAD_W));

    // One flight step; X and Y are independent so a corner reflects both axes.
    always_comb begin
        step_x    = ball_x;
        step_y    = ball_y;
        step_dx   = dx;
        step_dy   = dy;
        step_hit  = 1'b0;
        step_miss = 1'b0;

        if (dx == DIR_RIGHT) begin
            if (({1'b0, ball_x} + STEP_W) >= X_MAX) begin
                step_x  = X_MAX[9:0];
                step_dx = DIR_LEFT;
            end else begin
                step_x = ball_x + STEP_10;
            end
        end else begin
            if ({1'b0, ball_x} <= STEP_W) begin
                step_x  = 10'd0;
                step_dx = DIR_RIGHT;
            end else begin
                step_x = ball_x - STEP_10;
            end
        end

        if (dy == DIR_UP) begin
            if ({1'b0, ball_y} <= STEP_W) begin
                step_y  = 10'd0;
                step_dy = DIR_DOWN;
            end else begin
                step_y = ball_y - STEP_10;
            end
        end else if ((({1'b0, ball_y} + BALL_W) <= {1'b0, paddle_y}) &&
                     (({1'b0, ball_y} + BALL_W + STEP_W) >= {1'b0, paddle_y}) &&
                     over_paddle) begin
            step_y   = paddle_y - BALL_10;
            step_dy  = DIR_UP;
            step_hit = 1'b1;
        end else if (({1'b0, ball_y} + STEP_W) >= Y_MAX) begin
            step_y    = Y_MAX[9:0];
            step_miss = 1'b1;
        end else begin
            step_y = ball_y + STEP_10;
        end
    end

    always_comb begin
        state_next = state;
        x_next     = ball_x;
        y_next     = ball_y;
        dx_next    = dx;
        dy_next    = dy;
        hit_next   = 1'b0;
        miss_next  = 1'b0;

        unique case (state)
            IDLE: begin
                if (frame_tick) begin
                    x_next = paddle_x + SNAP_OFS;
                    y_next = paddle_y - BALL_10;
                end
                if (launch) begin
                    state_next = MOVE;
                    dx_next    = DIR_RIGHT;
                    dy_next    = DIR_UP;
                end
            end
            MOVE: begin
                if (frame_tick && !pause) begin
                    x_next    = step_x;
                    y_next    = step_y;
                    dx_next   = step_dx;
                    dy_next   = step_dy;
                    hit_next  = step_hit;
                    miss_next = step_miss;
                    if (step_miss) begin
                        state_next = LOST;
                    end
                end
            end
            LOST: begin
                if (frame_tick) begin
                    state_next = IDLE;
                    dx_next    = DIR_RIGHT;
                    dy_next    = DIR_UP;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
